// File: rtl/lvds_tx_framer.sv
// lvds_tx_framer: packs 140-bit sample words into 10-bit LVDS TX words with header, checksum, idle fill and training.
// Optional feature macro LVDS_TX_PRBS_EN adds prbs_mode, which replaces idle words with a PRBS7 stream.
module lvds_tx_framer #(
    parameter int         FRAME_WORDS = 4,
    parameter int         TRAIN_LEN   = 64,
    parameter logic [9:0] IDLE_WORD   = 10'h155,
    parameter logic [9:0] TRAIN_WORD  = 10'h3E0,
    parameter logic [9:0] FILL_WORD   = 10'h0F3
) (
    input  logic         clklvds,
    input  logic         rstn,
    input  logic         train_req,
`ifdef LVDS_TX_PRBS_EN
    input  logic         prbs_mode,
`endif
    input  logic         s_tvalid,
    output logic         s_tready,
    input  logic [139:0] s_tdata,
    output logic [9:0]   tx_data,
    output logic         tx_busy,
    output logic         training,
    output logic [15:0]  frame_count,
    output logic [7:0]   underrun_count
);

    typedef enum logic [2:0] {IDLE, TRAIN, HDR, PAYLOAD, FILL, CHK} state_e;

    localparam logic [7:0]  FW8     = 8'(FRAME_WORDS);
    localparam logic [15:0] TL_LAST = 16'(TRAIN_LEN - 1);

    state_e         state_q, state_d;
    logic [3:0]     sliceIdx_q, sliceIdx_d;
    logic [7:0]     wordIdx_q, wordIdx_d;
    logic [15:0]    trainCnt_q, trainCnt_d;
    logic [139:0]   shift_q, shift_d;
    logic [9:0]     sum_q, sum_d;
    logic [7:0]     seq_q, seq_d;
    logic           pending_q, pending_d;
    logic [9:0]     txData_q, txData_d;
    logic [15:0]    frameCnt_q, frameCnt_d;
    logic [7:0]     underrunCnt_q, underrunCnt_d;
    logic           accept;

`ifdef LVDS_TX_PRBS_EN
    logic [6:0]     prbs_q, prbs_d;

    // Fibonacci PRBS7 (x^7+x^6+1); first generated bit lands in bit 9.
    function automatic logic [16:0] prbsStep10(input logic [6:0] s);
        logic [6:0] st;
        logic [9:0] bits;
        logic       fb;
        st   = s;
        bits = '0;
        for (int i = 9; i >= 0; i--) begin
            fb      = st[6] ^ st[5];
            st      = {st[5:0], fb};
            bits[i] = fb;
        end
        return {st, bits};
    endfunction
`endif

    always_ff @(posedge clklvds or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            sliceIdx_q    <= '0;
            wordIdx_q     <= '0;
            trainCnt_q    <= '0;
            shift_q       <= '0;
            sum_q         <= '0;
            seq_q         <= '0;
            pending_q     <= 1'b0;
            txData_q      <= IDLE_WORD;
            frameCnt_q    <= '0;
            underrunCnt_q <= '0;
`ifdef LVDS_TX_PRBS_EN
            prbs_q        <= 7'h7F;
`endif
        end else begin
            state_q       <= state_d;
            sliceIdx_q    <= sliceIdx_d;
            wordIdx_q     <= wordIdx_d;
            trainCnt_q    <= trainCnt_d;
            shift_q       <= shift_d;
            sum_q         <= sum_d;
            seq_q         <= seq_d;
            pending_q     <= pending_d;
            txData_q      <= txData_d;
            frameCnt_q    <= frameCnt_d;
            underrunCnt_q <= underrunCnt_d;
`ifdef LVDS_TX_PRBS_EN
            prbs_q        <= prbs_d;
`endif
        end
    end

    // state_q names the word currently on tx_data; the checksum folds in each slice as it is scheduled.
    always_comb begin
        state_d       = state_q;
        sliceIdx_d    = sliceIdx_q;
        wordIdx_d     = wordIdx_q;
        trainCnt_d    = trainCnt_q;
        shift_d       = shift_q;
        sum_d         = sum_q;
        seq_d         = seq_q;
        pending_d     = pending_q;
        frameCnt_d    = frameCnt_q;
        underrunCnt_d = underrunCnt_q;
        accept        = s_tvalid & s_tready;

        if (train_req && state_q != TRAIN)
            pending_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d    = TRAIN;
                    trainCnt_d = '0;
                end else if (accept) begin
                    state_d   = HDR;
                    shift_d   = s_tdata;
                    wordIdx_d = 8'd1;
                    sum_d     = '0;
                end
            end
            TRAIN: begin
                if (trainCnt_q == TL_LAST) begin
                    state_d   = IDLE;
                    pending_d = 1'b0;
                end else begin
                    trainCnt_d = trainCnt_q + 16'd1;
                end
            end
            HDR: begin
                state_d    = PAYLOAD;
                sliceIdx_d = '0;
            end
            PAYLOAD: begin
                if (sliceIdx_q != 4'd13) begin
                    sliceIdx_d = sliceIdx_q + 4'd1;
                    shift_d    = {10'd0, shift_q[139:10]};
                end else if (wordIdx_q == FW8) begin
                    state_d = CHK;
                end else if (accept) begin
                    shift_d    = s_tdata;
                    sliceIdx_d = '0;
                    wordIdx_d  = wordIdx_q + 8'd1;
                end else begin
                    state_d = FILL;
                    if (underrunCnt_q != 8'hFF)
                        underrunCnt_d = underrunCnt_q + 8'd1;
                end
            end
            FILL: begin
                if (accept) begin
                    state_d    = PAYLOAD;
                    shift_d    = s_tdata;
                    sliceIdx_d = '0;
                    wordIdx_d  = wordIdx_q + 8'd1;
                end
            end
            CHK: begin
                state_d    = IDLE;
                seq_d      = seq_q + 8'd1;
                frameCnt_d = frameCnt_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == PAYLOAD)
            sum_d = sum_q + shift_d[9:0];
    end

    // s_tready is gated by rstn so it stays low while reset is asserted.
    always_comb begin
        s_tready = 1'b0;
        case (state_q)
            IDLE:    s_tready = !pending_q;
            PAYLOAD: s_tready = (sliceIdx_q == 4'd13) && (wordIdx_q < FW8);
            FILL:    s_tready = 1'b1;
            default: s_tready = 1'b0;
        endcase
`ifdef LVDS_TX_PRBS_EN
        if (prbs_mode)
            s_tready = s_tready && (state_q != IDLE);
        prbs_d = prbs_q;
`endif
        s_tready = s_tready & rstn;

        txData_d = IDLE_WORD;
        case (state_d)
            IDLE: begin
`ifdef LVDS_TX_PRBS_EN
                if (prbs_mode)
                    {prbs_d, txData_d} = prbsStep10(prbs_q);
`endif
            end
            TRAIN:   txData_d = TRAIN_WORD;
            HDR:     txData_d = {2'b11, seq_q};
            PAYLOAD: txData_d = shift_d[9:0];
            FILL:    txData_d = FILL_WORD;
            CHK:     txData_d = sum_q;
            default: txData_d = IDLE_WORD;
        endcase

        tx_busy  = state_q inside {HDR, PAYLOAD, FILL, CHK};
        training = (state_q == TRAIN);
    end

    assign tx_data        = txData_q;
    assign frame_count    = frameCnt_q;
    assign underrun_count = underrunCnt_q;

endmodule

// File: tb/tb_lvds_tx_framer.sv
// tb_lvds_tx_framer: directed test of lvds_tx_framer with FRAME_WORDS=2, TRAIN_LEN=8.
module tb_lvds_tx_framer;

    logic         clklvds = 1'b0;
    logic         rstn;
    logic         train_req;
    logic         s_tvalid;
    logic         s_tready;
    logic [139:0] s_tdata;
    logic [9:0]   tx_data;
    logic         tx_busy;
    logic         training;
    logic [15:0]  frame_count;
    logic [7:0]   underrun_count;

    int total = 0;
    int bad   = 0;

    logic [139:0] wordA;
    logic [139:0] wordB;

    lvds_tx_framer #(
        .FRAME_WORDS (2),
        .TRAIN_LEN   (8)
    ) dut (
        .clklvds        (clklvds),
        .rstn           (rstn),
        .train_req      (train_req),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .s_tdata        (s_tdata),
        .tx_data        (tx_data),
        .tx_busy        (tx_busy),
        .training       (training),
        .frame_count    (frame_count),
        .underrun_count (underrun_count)
    );

    always #5 clklvds = ~clklvds;

    function automatic logic [139:0] mkWord(input int base);
        logic [139:0] w;
        w = '0;
        for (int i = 0; i < 14; i++)
            w[i*10 +: 10] = 10'(base + i);
        return w;
    endfunction

    task automatic tick();
        @(posedge clklvds);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [139:0] data, input logic trainPulse);
        s_tvalid  = valid;
        s_tdata   = data;
        train_req = trainPulse;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One two-word frame: A (slices 1..14), optional gap of fill, B (slices 15..28), checksum, idle.
    task automatic sendFrame(input logic [7:0] seqExp, input int gap, input bit trainMid);
        applyStimulus(1'b1, wordA, 1'b0);
        checkOutput("idle_before", tx_data, 10'h155);
        checkOutput("ready_idle", s_tready, 1);
        tick();
        checkOutput("header", tx_data, {2'b11, seqExp});
        checkOutput("busy_hdr", tx_busy, 1);
        applyStimulus(gap == 0, wordB, 1'b0);
        for (int i = 0; i < 14; i++) begin
            tick();
            checkOutput("sliceA", tx_data, 10'(i + 1));
            train_req = trainMid && (i == 6);
            if (i == 13)
                checkOutput("ready_slice13", s_tready, 1);
        end
        for (int f = 1; f <= gap; f++) begin
            tick();
            checkOutput("fill", tx_data, 10'h0F3);
            if (f == gap)
                s_tvalid = 1'b1;
        end
        for (int i = 0; i < 14; i++) begin
            tick();
            checkOutput("sliceB", tx_data, 10'(i + 15));
            if (i == 0)
                s_tvalid = 1'b0;
        end
        tick();
        checkOutput("checksum", tx_data, 10'h196);
        checkOutput("busy_chk", tx_busy, 1);
        tick();
        checkOutput("idle_after", tx_data, 10'h155);
        checkOutput("busy_after", tx_busy, 0);
    endtask

    initial begin
        wordA = mkWord(1);
        wordB = mkWord(15);
        rstn  = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);

        $display("[TB] reset then idle");
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("rst_tx", tx_data, 10'h155);
            checkOutput("rst_ready", s_tready, 0);
            checkOutput("rst_busy", tx_busy, 0);
        end
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput("idle_tx", tx_data, 10'h155);
            checkOutput("idle_ready", s_tready, 1);
            checkOutput("idle_training", training, 0);
            checkOutput("idle_frames", frame_count, 0);
            checkOutput("idle_underruns", underrun_count, 0);
        end

        $display("[TB] single frame");
        sendFrame(8'h00, 0, 1'b0);
        checkOutput("frames_1", frame_count, 1);
        checkOutput("underruns_0", underrun_count, 0);

        $display("[TB] underrun of 5 cycles");
        sendFrame(8'h01, 5, 1'b0);
        checkOutput("underruns_1", underrun_count, 1);
        checkOutput("frames_2", frame_count, 2);

        $display("[TB] training request mid-frame");
        sendFrame(8'h02, 0, 1'b1);
        checkOutput("ready_pending", s_tready, 0);
        for (int c = 0; c < 8; c++) begin
            tick();
            checkOutput("train_word", tx_data, 10'h3E0);
            checkOutput("train_flag", training, 1);
            checkOutput("train_ready", s_tready, 0);
        end
        tick();
        checkOutput("post_train_tx", tx_data, 10'h155);
        checkOutput("post_train_flag", training, 0);
        checkOutput("post_train_ready", s_tready, 1);

        $display("[TB] async reset at slice 6 of word A");
        applyStimulus(1'b1, wordA, 1'b0);
        tick();
        checkOutput("rst_hdr", tx_data, 10'h303);
        applyStimulus(1'b0, wordB, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick();
            checkOutput("rst_slice", tx_data, 10'(i + 1));
        end
        #1 rstn = 1'b0;
        #1;
        checkOutput("rst_mid_tx", tx_data, 10'h155);
        checkOutput("rst_mid_busy", tx_busy, 0);
        checkOutput("rst_mid_frames", frame_count, 0);
        checkOutput("rst_mid_underruns", underrun_count, 0);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        checkOutput("rst_release_tx", tx_data, 10'h155);

        $display("[TB] 256 frames for sequence wrap");
        for (int n = 0; n < 256; n++)
            sendFrame(8'(n), 0, 1'b0);
        checkOutput("frames_256", frame_count, 256);
        sendFrame(8'h00, 0, 1'b0);
        checkOutput("frames_257", frame_count, 257);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lvds_tx_framer.md
Name: lvds_tx_framer

Overview:
- Transmit-side counterpart to the board's LVDS sample receive path.
- Accepts 140-bit sample words (14 slices × 10 bits, same packing as lvds1bits..lvds4bits).
- Serialises each word into one 10-bit word per clklvds cycle for the LVDS TX serializer, with framing, a per-frame checksum, idle fill and a link-training sequence.
- Used for board-to-board sample forwarding and for loopback testing of the receive path.

Parameters:
FRAME_WORDS, 4, 140-bit payload words per frame (1..255)
TRAIN_LEN, 64, cycles of training pattern per training request (1..65535)
IDLE_WORD, 10'h155, word sent when no frame is in progress
TRAIN_WORD, 10'h3E0, word sent during training
FILL_WORD, 10'h0F3, word sent on mid-frame payload underrun

Ports:
clklvds  in  1  LVDS slow clock; the only clock
rstn  in  1  asynchronous active-low reset
train_req  in  1  request a training burst; single-cycle pulse, latched
s_tvalid  in  1  payload word valid
s_tready  out  1  framer accepts s_tdata this cycle
s_tdata  in  140  payload word; slice i = bits [10i+9:10i]
tx_data  out  10  registered word to the LVDS TX serializer
tx_busy  out  1  high from header through checksum
training  out  1  high while TRAIN_WORD is being sent
frame_count  out  16  completed frames, wraps at 65535->0
underrun_count  out  8  underrun events, saturates at 255

Behaviour:
- Reset (async, rstn=0):
  - tx_data=IDLE_WORD; s_tready=0; tx_busy=0; training=0.
  - frame_count=0; underrun_count=0; seq=0; train pending cleared; state=IDLE.
  - Reset mid-frame abandons the frame immediately. No checksum is sent.
- States: IDLE, TRAIN, HDR, PAYLOAD, FILL, CHK.
- s_tready is combinational from state/counters:
  - 1 in IDLE when no train is pending.
  - 1 in PAYLOAD on slice 13 when words_sent < FRAME_WORDS.
  - 1 in FILL.
  - 0 otherwise.
- Acceptance = s_tvalid & s_tready.
- IDLE:
  - If train pending: go to TRAIN. Pending beats s_tvalid.
  - Else on acceptance: load shift register and go to HDR.
  - tx_data=IDLE_WORD.
- Frame timing, with a word accepted in IDLE at cycle t:
  - tx_data at t+1 = {2'b11, seq[7:0]}.
  - t+2..t+15 = slices 0..13 of the word, LSB slice first.
- PAYLOAD, slice 13 of word k < FRAME_WORDS:
  - On acceptance, the next cycle is slice 0 of the new word (no gap).
  - Otherwise go to FILL: underrun_count increments once (saturating) and tx_data=FILL_WORD every cycle until acceptance.
  - On acceptance in FILL, the next cycle is slice 0.
- After slice 13 of word FRAME_WORDS: one CHK cycle.
  - tx_data = 10-bit sum, mod 1024, of all 14×FRAME_WORDS payload slices.
  - Excludes header and fill words.
  - Then IDLE. seq += 1 (8-bit wrap); frame_count += 1.
  - At least one IDLE_WORD is emitted between frames.
- tx_busy=1 in HDR, PAYLOAD, FILL and CHK.
- Training:
  - A train_req pulse sets a sticky pending flag in any state except TRAIN; it is ignored during TRAIN.
  - Pending is honoured only from IDLE, never mid-frame.
  - TRAIN emits TRAIN_WORD for exactly TRAIN_LEN cycles with training=1, then returns to IDLE and clears pending.
- Simultaneous train_req and s_tvalid in IDLE: the word is accepted this cycle. Training starts after that frame completes.

Optional Feature:
LVDS_TX_PRBS_EN:
- When defined, adds input prbs_mode (1 bit).
- With prbs_mode=1 in IDLE:
  - tx_data carries a PRBS7 sequence (x^7+x^6+1, seed 7'h7F), 10 bits advanced per cycle.
  - s_tready=0.
  - Training requests are still honoured.
- When not defined: no port and no PRBS logic. IDLE always emits IDLE_WORD.

Test Plan:
- Test parameters: FRAME_WORDS=2, TRAIN_LEN=8.
- Reset then idle: rstn low 3 cycles, release, no stimulus -> tx_data=10'h155 every cycle; s_tready=1; counters 0.
- Single frame:
  - Stimulus: word A with slices 1..14, then word B with slices 15..28, both valid continuously.
  - Required tx_data: 10'h300; 1..14; 15..28; checksum 406 (10'h196); then 10'h155.
  - frame_count=1; next header 10'h301.
- Underrun: withhold B for 5 cycles after A slice 13 -> exactly 5×10'h0F3; underrun_count=1; checksum unchanged at 10'h196.
- Training: pulse train_req mid-frame -> frame completes intact, then 1 IDLE word, then 8×10'h3E0 with training=1, then 10'h155.
- Async reset at slice 6 of word A -> tx_data=10'h155 and seq=0 immediately. The next frame header is 10'h300.
- Wrap: run 256 frames -> header seq rolls 10'h3FF -> 10'h300; frame_count=256.
